// File: rtl/udt_pkg.sv
// Shared UDT definitions: control-packet types, connection state codes,
// control-header field layout and the close_packet_gen FSM encoding.
package udt_pkg;

  localparam logic [14:0] UDT_CTRL_SHUTDOWN = 15'h0005;

  // Control header layout (64-bit beat, first 32-bit word on [63:32])
  localparam int HDR_CTRL_BIT = 63;
  localparam int HDR_TYPE_LSB = 48;
  localparam int HDR_RSVD_LSB = 32;
  localparam int HDR_INFO_LSB = 0;

  typedef enum logic [31:0] {
    UDT_ST_NONE       = 32'd0,
    UDT_ST_INIT       = 32'd1,
    UDT_ST_OPENED     = 32'd2,
    UDT_ST_LISTENING  = 32'd3,
    UDT_ST_CONNECTING = 32'd4,
    UDT_ST_CONNECTED  = 32'd5,
    UDT_ST_CLOSED     = 32'd6
  } udt_conn_state_e;

  typedef enum logic [2:0] {
    CPG_IDLE,
    CPG_DRAIN,
    CPG_BEAT0,
    CPG_BEAT1,
    CPG_REPORT,
    CPG_DONE
  } cpg_state_e;

  function automatic logic [63:0] udt_ctrl_header(input logic [14:0] ctrl_type,
                                                  input logic [31:0] add_info);
    logic [63:0] hdr;
    hdr = '0;
    hdr[HDR_CTRL_BIT]        = 1'b1;
    hdr[HDR_TYPE_LSB +: 15]  = ctrl_type;
    hdr[HDR_RSVD_LSB +: 16]  = 16'h0000;
    hdr[HDR_INFO_LSB +: 32]  = add_info;
    return hdr;
  endfunction

endpackage

// File: rtl/close_packet_gen_if.sv
// Signal bundle between close_packet_gen and its neighbours: close request,
// send-buffer status, shutdown-packet AXI-Stream and state report.
interface close_packet_gen_if;
  logic        close_req_i;
  logic [31:0] dst_sock_id_i;
  logic [31:0] timestamp_i;
  logic        SND_BUFFER_EMPTY_i;
  logic        close_tvalid_o;
  logic [63:0] close_tdata_o;
  logic [7:0]  close_tkeep_o;
  logic        close_tlast_o;
  logic        close_tready_i;
  logic [31:0] udt_state_o;
  logic        state_valid_o;
  logic        state_ready_i;
  logic        busy_o;
  logic        closed_o;
  logic        drain_timeout_o;

  modport master (
    input  close_req_i, dst_sock_id_i, timestamp_i, SND_BUFFER_EMPTY_i,
           close_tready_i, state_ready_i,
    output close_tvalid_o, close_tdata_o, close_tkeep_o, close_tlast_o,
           udt_state_o, state_valid_o, busy_o, closed_o, drain_timeout_o
  );

  modport slave (
    output close_req_i, dst_sock_id_i, timestamp_i, SND_BUFFER_EMPTY_i,
           close_tready_i, state_ready_i,
    input  close_tvalid_o, close_tdata_o, close_tkeep_o, close_tlast_o,
           udt_state_o, state_valid_o, busy_o, closed_o, drain_timeout_o
  );
endinterface

// File: rtl/udt_drain_timer.sv
// Saturating 32-bit cycle counter with clear/enable; expired_o flags the
// last cycle of a TIMEOUT-cycle window (never, when TIMEOUT is 0).
module udt_drain_timer #(
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (TIMEOUT != 32'd0) && (cnt_q == TIMEOUT - 32'd1);
endmodule

// File: rtl/close_packet_gen.sv
// Connection teardown TX: waits for the send buffer to drain (or time out),
// sends a two-beat UDT SHUTDOWN packet, then reports the CLOSED state.
module close_packet_gen
  import udt_pkg::*;
#(
  parameter logic [31:0] DRAIN_TIMEOUT = 32'd1_000_000,
  parameter logic [31:0] STATE_CLOSED  = 32'd6
) (
  input  logic               core_clk,
  input  logic               core_rst,
  close_packet_gen_if.master cp
);
  cpg_state_e  state_q;
  logic        tvalid_q, tlast_q, state_valid_q, busy_q, closed_q, timeout_q;
  logic [63:0] tdata_q;
  logic [7:0]  tkeep_q;
  logic [31:0] udt_state_q;
  logic [31:0] sock_q, ts_q;
  logic        expired, drain_go;

  udt_drain_timer #(.TIMEOUT(DRAIN_TIMEOUT)) u_drain_timer (
    .clk_i     (core_clk),
    .rst_i     (core_rst),
    .clr_i     (state_q == CPG_IDLE),
    .en_i      (state_q == CPG_DRAIN),
    .expired_o (expired)
  );

  // Empty buffer takes priority, so a simultaneous expiry is not reported.
  assign drain_go = cp.SND_BUFFER_EMPTY_i || expired;

  // Packet fields are captured on the DRAIN exit edge; no reset needed.
  always_ff @(posedge core_clk) begin
    if ((state_q == CPG_DRAIN) && drain_go) begin
      sock_q <= cp.dst_sock_id_i;
      ts_q   <= cp.timestamp_i;
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q       <= CPG_IDLE;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      tlast_q       <= 1'b0;
      udt_state_q   <= '0;
      state_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      closed_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        CPG_IDLE: begin
          if (cp.close_req_i) begin
            state_q <= CPG_DRAIN;
            busy_q  <= 1'b1;
          end
        end
        CPG_DRAIN: begin
          if (drain_go) begin
            state_q   <= CPG_BEAT0;
            timeout_q <= !cp.SND_BUFFER_EMPTY_i;
            tvalid_q  <= 1'b1;
            tdata_q   <= udt_ctrl_header(UDT_CTRL_SHUTDOWN, 32'h0000_0000);
            tkeep_q   <= 8'hFF;
            tlast_q   <= 1'b0;
          end
        end
        CPG_BEAT0: begin
          if (cp.close_tready_i) begin
            state_q <= CPG_BEAT1;
            tdata_q <= {ts_q, sock_q};
            tlast_q <= 1'b1;
          end
        end
        CPG_BEAT1: begin
          if (cp.close_tready_i) begin
            state_q       <= CPG_REPORT;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
            tlast_q       <= 1'b0;
            udt_state_q   <= STATE_CLOSED;
            state_valid_q <= 1'b1;
          end
        end
        CPG_REPORT: begin
          if (cp.state_ready_i) begin
            state_q       <= CPG_DONE;
            state_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            closed_q      <= 1'b1;
          end
        end
        CPG_DONE: ;
        default:  state_q <= CPG_IDLE;
      endcase
    end
  end

  assign cp.close_tvalid_o  = tvalid_q;
  assign cp.close_tdata_o   = tdata_q;
  assign cp.close_tkeep_o   = tkeep_q;
  assign cp.close_tlast_o   = tlast_q;
  assign cp.udt_state_o     = udt_state_q;
  assign cp.state_valid_o   = state_valid_q;
  assign cp.busy_o          = busy_q;
  assign cp.closed_o        = closed_q;
  assign cp.drain_timeout_o = timeout_q;
endmodule

// File: tb/tb_close_packet_gen.sv
// Bench for close_packet_gen: a long-timeout instance (1000) and a
// short-timeout instance (20) driven from one sequence of scenario tasks.
module tb_close_packet_gen;
  localparam logic [63:0] HDR = 64'h8005_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  close_packet_gen_if ifa ();
  close_packet_gen_if ifb ();

  close_packet_gen #(.DRAIN_TIMEOUT(32'd1000), .STATE_CLOSED(32'd6)) dut_a (
    .core_clk(clk), .core_rst(rst), .cp(ifa));
  close_packet_gen #(.DRAIN_TIMEOUT(32'd20), .STATE_CLOSED(32'd6)) dut_b (
    .core_clk(clk), .core_rst(rst), .cp(ifb));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs;
    ifa.close_req_i = 0; ifa.dst_sock_id_i = '0; ifa.timestamp_i = '0;
    ifa.SND_BUFFER_EMPTY_i = 0; ifa.close_tready_i = 0; ifa.state_ready_i = 0;
    ifb.close_req_i = 0; ifb.dst_sock_id_i = '0; ifb.timestamp_i = '0;
    ifb.SND_BUFFER_EMPTY_i = 0; ifb.close_tready_i = 0; ifb.state_ready_i = 0;
  endtask

  task automatic apply_reset;
    init_inputs();
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    logic [110:0] oa, ob;
    init_inputs();
    rst = 1'b1;
    tick();
    oa = {ifa.close_tvalid_o, ifa.close_tdata_o, ifa.close_tkeep_o, ifa.close_tlast_o,
          ifa.udt_state_o, ifa.state_valid_o, ifa.busy_o, ifa.closed_o, ifa.drain_timeout_o};
    ob = {ifb.close_tvalid_o, ifb.close_tdata_o, ifb.close_tkeep_o, ifb.close_tlast_o,
          ifb.udt_state_o, ifb.state_valid_o, ifb.busy_o, ifb.closed_o, ifb.drain_timeout_o};
    vectors++;
    if (oa !== '0) begin miscompares++; $display("FAIL reset_outputs_a: got %h expected 0", oa); end
    vectors++;
    if (ob !== '0) begin miscompares++; $display("FAIL reset_outputs_b: got %h expected 0", ob); end
    #3 rst = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ifa.close_tvalid_o, ifa.busy_o, ifa.state_valid_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_no_request: got %b expected 000",
               {ifa.close_tvalid_o, ifa.busy_o, ifa.state_valid_o});
    end
  endtask

  task automatic test_min_latency;
    logic [31:0] ts, sock;
    apply_reset();
    ts = $urandom; sock = $urandom;
    ifa.SND_BUFFER_EMPTY_i = 1; ifa.close_tready_i = 1; ifa.state_ready_i = 1;
    ifa.timestamp_i = ts; ifa.dst_sock_id_i = sock;
    ifa.close_req_i = 1;
    tick();
    ifa.close_req_i = 0;
    vectors++;
    if ({ifa.busy_o, ifa.close_tvalid_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL min_drain_entry: busy,tvalid got %b expected 10", {ifa.busy_o, ifa.close_tvalid_o});
    end
    tick();
    ifa.timestamp_i = ~ts; ifa.dst_sock_id_i = ~sock;
    vectors++;
    if ({ifa.close_tvalid_o, ifa.close_tdata_o, ifa.close_tkeep_o, ifa.close_tlast_o} !==
        {1'b1, HDR, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL min_beat0: got v=%b d=%h k=%h l=%b expected v=1 d=%h k=ff l=0",
               ifa.close_tvalid_o, ifa.close_tdata_o, ifa.close_tkeep_o, ifa.close_tlast_o, HDR);
    end
    tick();
    vectors++;
    if ({ifa.close_tvalid_o, ifa.close_tdata_o, ifa.close_tkeep_o, ifa.close_tlast_o} !==
        {1'b1, ts, sock, 8'hFF, 1'b1}) begin
      miscompares++;
      $display("FAIL min_beat1: got v=%b d=%h l=%b expected v=1 d=%h%h l=1",
               ifa.close_tvalid_o, ifa.close_tdata_o, ifa.close_tlast_o, ts, sock);
    end
    tick();
    vectors++;
    if ({ifa.close_tvalid_o, ifa.state_valid_o, ifa.udt_state_o} !== {1'b0, 1'b1, 32'd6}) begin
      miscompares++;
      $display("FAIL min_report: got tv=%b sv=%b st=%0d expected tv=0 sv=1 st=6",
               ifa.close_tvalid_o, ifa.state_valid_o, ifa.udt_state_o);
    end
    tick();
    vectors++;
    if ({ifa.closed_o, ifa.busy_o, ifa.drain_timeout_o, ifa.state_valid_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL min_done: closed,busy,dto,sv got %b expected 1000",
               {ifa.closed_o, ifa.busy_o, ifa.drain_timeout_o, ifa.state_valid_o});
    end
  endtask

  // Runs straight after test_min_latency, with the block sitting in DONE.
  task automatic test_ignore_after_done;
    int seen;
    seen = 0;
    ifa.close_req_i = 1;
    tick();
    ifa.close_req_i = 0;
    for (int k = 0; k < 10; k++) begin
      if (ifa.close_tvalid_o || ifa.state_valid_o) seen++;
      tick();
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL done_ignores_req: activity cycles got %0d expected 0", seen); end
    vectors++;
    if ({ifa.closed_o, ifa.busy_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL done_sticky: closed,busy got %b expected 10", {ifa.closed_o, ifa.busy_o});
    end
  endtask

  task automatic test_drain_empty;
    logic [31:0] ts, sock;
    int seen;
    apply_reset();
    seen = 0;
    ifa.close_tready_i = 1; ifa.state_ready_i = 1;
    ifa.close_req_i = 1;
    tick();
    ifa.close_req_i = 0;
    for (int k = 1; k <= 50; k++) begin
      ifa.timestamp_i = $urandom; ifa.dst_sock_id_i = $urandom;
      ifa.close_req_i = (k == 10);
      tick();
      if (ifa.close_tvalid_o) seen++;
    end
    ifa.close_req_i = 0;
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL drain_holds: tvalid cycles got %0d expected 0", seen); end
    ts = $urandom; sock = $urandom;
    ifa.SND_BUFFER_EMPTY_i = 1; ifa.timestamp_i = ts; ifa.dst_sock_id_i = sock;
    tick();
    ifa.timestamp_i = $urandom; ifa.dst_sock_id_i = $urandom;
    vectors++;
    if ({ifa.close_tvalid_o, ifa.close_tdata_o} !== {1'b1, HDR}) begin
      miscompares++;
      $display("FAIL drain_beat0: got v=%b d=%h expected v=1 d=%h", ifa.close_tvalid_o, ifa.close_tdata_o, HDR);
    end
    tick();
    vectors++;
    if ({ifa.close_tdata_o, ifa.close_tlast_o} !== {ts, sock, 1'b1}) begin
      miscompares++;
      $display("FAIL drain_beat1: got d=%h l=%b expected d=%h%h l=1", ifa.close_tdata_o, ifa.close_tlast_o, ts, sock);
    end
    tick();
    tick();
    vectors++;
    if ({ifa.closed_o, ifa.drain_timeout_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL drain_no_timeout: closed,dto got %b expected 10", {ifa.closed_o, ifa.drain_timeout_o});
    end
  endtask

  task automatic test_timeout;
    int seen;
    // Buffer never empties: BEAT0 exactly 20 cycles after DRAIN entry.
    apply_reset();
    seen = 0;
    ifb.close_tready_i = 1; ifb.state_ready_i = 1;
    ifb.close_req_i = 1;
    tick();
    ifb.close_req_i = 0;
    for (int k = 1; k < 20; k++) begin
      ifb.close_req_i = (k == 5);
      tick();
      if (ifb.close_tvalid_o) seen++;
    end
    ifb.close_req_i = 0;
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL timeout_early: tvalid cycles got %0d expected 0", seen); end
    tick();
    vectors++;
    if ({ifb.close_tvalid_o, ifb.close_tdata_o, ifb.drain_timeout_o} !== {1'b1, HDR, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_beat0: got v=%b d=%h dto=%b expected v=1 d=%h dto=1",
               ifb.close_tvalid_o, ifb.close_tdata_o, ifb.drain_timeout_o, HDR);
    end
    tick(); tick(); tick();
    vectors++;
    if ({ifb.closed_o, ifb.drain_timeout_o, ifb.busy_o} !== 3'b110) begin
      miscompares++;
      $display("FAIL timeout_done: closed,dto,busy got %b expected 110",
               {ifb.closed_o, ifb.drain_timeout_o, ifb.busy_o});
    end
    // Empty arrives on the very cycle the timer expires: empty wins.
    apply_reset();
    ifb.close_tready_i = 1; ifb.state_ready_i = 1;
    ifb.close_req_i = 1;
    tick();
    ifb.close_req_i = 0;
    for (int k = 1; k < 20; k++) tick();
    ifb.SND_BUFFER_EMPTY_i = 1;
    tick();
    vectors++;
    if ({ifb.close_tvalid_o, ifb.drain_timeout_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL tie_empty_wins: tvalid,dto got %b expected 10", {ifb.close_tvalid_o, ifb.drain_timeout_o});
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ets, esock, snap_state;
    logic [63:0] exp_beat, snap_data;
    logic [8:0]  snap_ctl;
    bit cap, tstall, sstall, rdy, srdy, emp;
    int d, nbeats, nrep;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      d = $urandom_range(8, 0);
      cap = 0; tstall = 0; sstall = 0; nbeats = 0; nrep = 0;
      ets = '0; esock = '0; snap_data = '0; snap_ctl = '0; snap_state = '0;
      ifa.close_req_i = 1;
      tick();
      ifa.close_req_i = 0;
      for (int cyc = 0; cyc < 120; cyc++) begin
        if (tstall) begin
          vectors++;
          if ({ifa.close_tvalid_o, ifa.close_tdata_o, ifa.close_tkeep_o, ifa.close_tlast_o} !==
              {1'b1, snap_data, snap_ctl}) begin
            miscompares++;
            $display("FAIL bp_beat_stable: got v=%b d=%h expected v=1 d=%h",
                     ifa.close_tvalid_o, ifa.close_tdata_o, snap_data);
          end
        end
        if (sstall) begin
          vectors++;
          if ({ifa.state_valid_o, ifa.udt_state_o} !== {1'b1, snap_state}) begin
            miscompares++;
            $display("FAIL bp_state_stable: got sv=%b st=%0d expected sv=1 st=%0d",
                     ifa.state_valid_o, ifa.udt_state_o, snap_state);
          end
        end
        rdy  = ($urandom_range(1, 0) == 1);
        srdy = ($urandom_range(1, 0) == 1);
        emp  = (cyc >= d);
        ifa.close_tready_i = rdy; ifa.state_ready_i = srdy; ifa.SND_BUFFER_EMPTY_i = emp;
        ifa.timestamp_i = $urandom; ifa.dst_sock_id_i = $urandom;
        ifa.close_req_i = ($urandom_range(7, 0) == 0);
        if (!cap && emp) begin cap = 1; ets = ifa.timestamp_i; esock = ifa.dst_sock_id_i; end
        if (ifa.close_tvalid_o && rdy) begin
          exp_beat = (nbeats == 0) ? HDR : {ets, esock};
          vectors++;
          if ({ifa.close_tdata_o, ifa.close_tkeep_o, ifa.close_tlast_o} !== {exp_beat, 8'hFF, nbeats == 1}) begin
            miscompares++;
            $display("FAIL bp_beat%0d: got d=%h k=%h l=%b expected d=%h k=ff l=%b", nbeats,
                     ifa.close_tdata_o, ifa.close_tkeep_o, ifa.close_tlast_o, exp_beat, nbeats == 1);
          end
          nbeats++;
        end
        tstall = ifa.close_tvalid_o && !rdy;
        snap_data = ifa.close_tdata_o; snap_ctl = {ifa.close_tkeep_o, ifa.close_tlast_o};
        if (ifa.state_valid_o && srdy) begin
          vectors++;
          if (ifa.udt_state_o !== 32'd6) begin
            miscompares++;
            $display("FAIL bp_report: got st=%0d expected 6", ifa.udt_state_o);
          end
          nrep++;
        end
        sstall = ifa.state_valid_o && !srdy;
        snap_state = ifa.udt_state_o;
        tick();
      end
      ifa.close_req_i = 0;
      vectors++;
      if (nbeats != 2) begin miscompares++; $display("FAIL bp_beat_count: got %0d expected 2", nbeats); end
      vectors++;
      if (nrep != 1) begin miscompares++; $display("FAIL bp_report_count: got %0d expected 1", nrep); end
      vectors++;
      if ({ifa.closed_o, ifa.busy_o, ifa.drain_timeout_o} !== 3'b100) begin
        miscompares++;
        $display("FAIL bp_final: closed,busy,dto got %b expected 100",
                 {ifa.closed_o, ifa.busy_o, ifa.drain_timeout_o});
      end
    end
  endtask

  task automatic test_reset_mid_packet;
    logic [31:0] ts, sock;
    apply_reset();
    ifa.SND_BUFFER_EMPTY_i = 1; ifa.close_tready_i = 1; ifa.state_ready_i = 1;
    ifa.close_req_i = 1;
    tick();
    ifa.close_req_i = 0;
    tick();
    tick();
    ifa.close_tready_i = 0;
    vectors++;
    if ({ifa.close_tvalid_o, ifa.close_tlast_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_mid_setup: tvalid,tlast got %b expected 11", {ifa.close_tvalid_o, ifa.close_tlast_o});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ifa.close_tvalid_o, ifa.busy_o, ifa.close_tdata_o} !== {2'b00, 64'h0}) begin
      miscompares++;
      $display("FAIL rst_mid_drop: tvalid,busy got %b expected 00",  {ifa.close_tvalid_o, ifa.busy_o});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (ifa.close_tvalid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_idle: tvalid got %b expected 0", ifa.close_tvalid_o);
    end
    ts = $urandom; sock = $urandom;
    ifa.timestamp_i = ts; ifa.dst_sock_id_i = sock; ifa.close_tready_i = 1;
    ifa.close_req_i = 1;
    tick();
    ifa.close_req_i = 0;
    tick();
    vectors++;
    if ({ifa.close_tvalid_o, ifa.close_tdata_o} !== {1'b1, HDR}) begin
      miscompares++;
      $display("FAIL rst_retry_beat0: got v=%b d=%h expected v=1 d=%h", ifa.close_tvalid_o, ifa.close_tdata_o, HDR);
    end
    tick();
    vectors++;
    if ({ifa.close_tdata_o, ifa.close_tlast_o} !== {ts, sock, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_retry_beat1: got d=%h l=%b expected d=%h%h l=1", ifa.close_tdata_o, ifa.close_tlast_o, ts, sock);
    end
    tick();
    tick();
    vectors++;
    if ({ifa.closed_o, ifa.busy_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_retry_done: closed,busy got %b expected 10", {ifa.closed_o, ifa.busy_o});
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_ignore_after_done();
    test_drain_empty();
    test_timeout();
    test_backpressure();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/close_packet_gen.md
# close_packet_gen

Transmit side of connection teardown. On a local close request, the block waits for the send buffer to drain, or for a drain timeout. It then emits one UDT SHUTDOWN control packet (two 64-bit AXI-Stream beats) toward the packet multiplexer and reports the CLOSED connection state to the core state register. It sits in the core control-packet TX path, alongside the other control-packet generators.

## Interface
- DRAIN_TIMEOUT, 32'd1_000_000, max cycles to wait for empty send buffer; 0 = wait forever
- STATE_CLOSED, 32'd6, code driven on udt_state_o after shutdown is sent
- core_clk  in  1  core clock; all logic on rising edge
- core_rst  in  1  asynchronous, active-high reset
- close_req_i  in  1  one-cycle close request from user/core control
- dst_sock_id_i  in  32  peer socket ID, latched at send start
- timestamp_i  in  32  core µs timer, latched at send start
- SND_BUFFER_EMPTY_i  in  1  send buffer fully drained and acknowledged
- close_tvalid_o  out  1  shutdown packet beat valid
- close_tdata_o  out  64  shutdown packet beat; first 32-bit word on [63:32]
- close_tkeep_o  out  8  byte enables
- close_tlast_o  out  1  last beat
- close_tready_i  in  1  downstream ready
- udt_state_o  out  32  connection state
- state_valid_o  out  1  state valid
- state_ready_i  in  1  state ready
- busy_o  out  1  close sequence in progress
- closed_o  out  1  sticky, set once state report is accepted
- drain_timeout_o  out  1  sticky, drain ended by timeout rather than empty buffer

## Operation
- FSM states: IDLE, DRAIN, BEAT0, BEAT1, REPORT, DONE.
- IDLE: when close_req_i=1, go to DRAIN, clear the drain counter, and set busy_o=1.
- DRAIN: go to BEAT0 when SND_BUFFER_EMPTY_i=1.
  - Otherwise, when DRAIN_TIMEOUT≠0 and the counter reaches DRAIN_TIMEOUT-1, go to BEAT0 and set drain_timeout_o.
  - If both conditions hold in the same cycle, the empty buffer wins and drain_timeout_o stays 0.
  - On the transition to BEAT0, latch dst_sock_id_i and timestamp_i.
- BEAT0: drive tdata = {1'b1, 15'h0005, 16'h0000, 32'h0000_0000} (control flag, type SHUTDOWN, reserved, additional info), tkeep=8'hFF, tlast=0. Go to BEAT1 on tvalid&&tready.
- BEAT1: drive tdata = {timestamp_latched, dst_sock_id_latched}, tkeep=8'hFF, tlast=1. Go to REPORT on handshake.
- REPORT: drive udt_state_o=STATE_CLOSED with state_valid_o=1. Go to DONE on state_ready_i.
- DONE: closed_o=1 and busy_o=0. The state is terminal; only reset leaves it.
- close_req_i is ignored in every state except IDLE.
- Drain counter: 32-bit, saturating, counts only in DRAIN.

## Timing
- Reset values: all outputs 0, FSM in IDLE. Asynchronous reset mid-packet drops close_tvalid_o immediately; no partial-packet completion.
- Minimum latency: close_req_i sampled at edge N with buffer empty gives close_tvalid_o=1 after edge N+1 (BEAT0). With tready held high, BEAT1 is presented after N+2 and state_valid_o after N+3.
- AXI rule: once tvalid=1, tdata/tkeep/tlast stay stable and tvalid stays high until the handshake. tvalid never depends combinationally on tready.
- state_valid_o and udt_state_o stay stable until state_ready_i. Outputs are registered.
- Timeout example: with DRAIN_TIMEOUT=T and the buffer never empty, BEAT0 is presented T cycles after entering DRAIN.

## Structure
- Shared package udt_pkg holds: UDT_CTRL_SHUTDOWN=15'h0005, connection state codes (including CLOSED), and the control-header field positions.
- One natural sub-module: udt_drain_timer (saturating counter with enable/clear and an expired flag), reusable by other teardown and keepalive logic.
- FSM and beat mux stay in close_packet_gen.

## Test plan
- Buffer empty, close_req_i pulse, tready=1 -> beat0 = 64'h8005_0000_0000_0000, beat1 = {timestamp, sock_id} with tlast=1, then udt_state_o=6 valid, closed_o=1, drain_timeout_o=0.
- Buffer non-empty for 50 cycles, DRAIN_TIMEOUT=1000 -> packet starts 1 cycle after empty asserts; drain_timeout_o=0.
- Buffer never empty, DRAIN_TIMEOUT=20 -> BEAT0 valid 20 cycles after DRAIN entry; drain_timeout_o=1.
- Random tready/state_ready backpressure -> beats stable while stalled, exactly 2 beats and 1 state report.
- Second close_req_i during DRAIN and after DONE -> no extra packet.
- core_rst asserted during BEAT1 -> tvalid=0 at once, FSM in IDLE; a new request produces a full packet.
